// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, sign-corrected in a final cycle.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               div_q, div_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   raw_a_q, raw_a_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               sign_q, sign_d;
  logic               rsign_q, rsign_d;
  logic               dz_q, dz_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next;
  logic [WIDTH-1:0]   quot, rem;

  always_comb begin
    a_neg = ~op[0] & src_a[WIDTH-1];
    b_neg = ~op[0] & src_b[WIDTH-1];
    a_mag = a_neg ? (~src_a + 1'b1) : src_a;
    b_mag = b_neg ? (~src_b + 1'b1) : src_b;

    // Multiply: add multiplicand into the upper half (with carry), then shift right.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

    // Divide: trial subtract on the shifted remainder, which needs WIDTH+1 bits.
    div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                 : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    quot = acc_q[WIDTH-1:0];
    rem  = acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    opnd_d  = opnd_q;
    raw_a_d = raw_a_q;
    acc_d   = acc_q;
    sign_d  = sign_q;
    rsign_d = rsign_q;
    dz_d    = dz_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          div_d   = op[1];
          opnd_d  = op[1] ? b_mag : a_mag;
          acc_d   = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
          sign_d  = a_neg ^ b_neg;
          rsign_d = a_neg;
          dz_d    = (src_b == '0);
          raw_a_d = src_a;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          if (hi_we) hi_d = src_a;
          if (lo_we) lo_d = src_a;
        end
      end
      StRun: begin
        acc_d = div_q ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = StFix;
      end
      StFix: begin
        if (!div_q) begin
          {hi_d, lo_d} = sign_q ? (~acc_q + 1'b1) : acc_q;
        end else if (dz_q) begin
          lo_d = '1;
          hi_d = raw_a_q;
        end else begin
          lo_d = sign_q ? (~quot + 1'b1) : quot;
          hi_d = rsign_q ? (~rem + 1'b1) : rem;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      div_q   <= 1'b0;
      opnd_q  <= '0;
      raw_a_q <= '0;
      acc_q   <= '0;
      sign_q  <= 1'b0;
      rsign_q <= 1'b0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      opnd_q  <= opnd_d;
      raw_a_q <= raw_a_d;
      acc_q   <= acc_d;
      sign_q  <= sign_d;
      rsign_q <= rsign_d;
      dz_q    <= dz_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != StIdle);
  assign done = done_q;

endmodule
